load_store_unit: RTL

Initiator side of the data-memory interface in the RISC-V datapath. Accepts byte-addressed load/store requests from the execute stage, issues word-indexed accesses to the 64-bit data memory, and sign/zero-extends load data. Sub-doubleword stores become read-modify-write sequences. Misaligned, illegal or out-of-range requests are flagged without touching memory.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_align.sv | 47 ++++
 rtl/load_store_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Covers funct3 encodings, FSM states, and the request legality check.
package lsu_pkg;

    localparam int XLEN = 64;
    localparam int OFFW = 3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        ERR,
        RESP
    } lsuState_t;

    // funct3[1:0] encodes access size for both loads and stores.
    function automatic logic isBadReq(input logic write, input logic [2:0] funct3,
                                      input logic [OFFW-1:0] offset);
        logic illegal;
        logic misaligned;
        illegal = write ? funct3[2] : (funct3 == 3'b111);
        case (funct3[1:0])
            2'b01:   misaligned = offset[0];
            2'b10:   misaligned = |offset[1:0];
            2'b11:   misaligned = |offset;
            default: misaligned = 1'b0;
        endcase
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane logic: extract + sign/zero-extend a load lane, merge a store lane into a word.
// Purely combinational; no handshake.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [OFFW-1:0] offset,
    input  logic [XLEN-1:0] oldWord,
    input  logic [XLEN-1:0] newData,
    output logic [XLEN-1:0] loadData,
    output logic [XLEN-1:0] storeWord
);

    logic [5:0]      bitOff;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] laneMask;

    assign bitOff  = {offset, 3'b000};
    assign shifted = oldWord >> bitOff;

    always_comb begin
        loadData = '0;
        case (funct3)
            F3_B:    loadData = {{56{shifted[7]}}, shifted[7:0]};
            F3_H:    loadData = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    loadData = {{32{shifted[31]}}, shifted[31:0]};
            F3_D:    loadData = shifted;
            F3_BU:   loadData = {56'd0, shifted[7:0]};
            F3_HU:   loadData = {48'd0, shifted[15:0]};
            F3_WU:   loadData = {32'd0, shifted[31:0]};
            default: loadData = '0;
        endcase
    end

    always_comb begin
        laneMask = '1;
        case (funct3[1:0])
            2'b00:   laneMask = 64'h0000_0000_0000_00FF;
            2'b01:   laneMask = 64'h0000_0000_0000_FFFF;
            2'b10:   laneMask = 64'h0000_0000_FFFF_FFFF;
            default: laneMask = '1;
        endcase
    end

    assign storeWord = (oldWord & ~(laneMask << bitOff)) | ((newData & laneMask) << bitOff);

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: load 2 cycles, sb/sh/sw 3 (read-modify-write), sd 2, error 2 to resp_valid.
// req_ready only in IDLE; one request in flight, requester holds req_valid until accepted.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 101
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_error,
    output logic [63:0] mem_address,
    output logic [63:0] mem_writeData,
    output logic        mem_memWrite,
    output logic        mem_memRead,
    input  logic [63:0] mem_readData
);

    localparam logic [XLEN-4:0] INDEX_LIMIT = (XLEN-3)'(MEM_WORDS);

    lsuState_t       state;
    lsuState_t       nextState;
    logic [XLEN-1:0] addrQ;
    logic [XLEN-1:0] wdataQ;
    logic [XLEN-1:0] oldQ;
    logic [XLEN-1:0] rdataQ;
    logic [2:0]      funct3Q;
    logic            writeQ;
    logic            errQ;
    logic            accept;
    logic            reqBad;
    logic [XLEN-1:0] alignOld;
    logic [XLEN-1:0] alignLoad;
    logic [XLEN-1:0] alignStore;

    assign accept = req_valid && req_ready;
    assign reqBad = isBadReq(req_write, req_funct3, req_addr[2:0]) ||
                    (req_addr[XLEN-1:3] >= INDEX_LIMIT);

    // READ works on live memory data; WRITE merges into the word captured during READ.
    assign alignOld = (state == WRITE) ? oldQ : mem_readData;

    lsu_align uAlign (
        .funct3   (funct3Q),
        .offset   (addrQ[2:0]),
        .oldWord  (alignOld),
        .newData  (wdataQ),
        .loadData (alignLoad),
        .storeWord(alignStore)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState     = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        mem_memRead   = 1'b0;
        mem_memWrite  = 1'b0;
        mem_writeData = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (reqBad) begin
                        nextState = ERR;
                    end else if (req_write && (req_funct3 == F3_D)) begin
                        nextState = WRITE;
                    end else begin
                        nextState = READ;
                    end
                end
            end
            READ: begin
                mem_memRead = 1'b1;
                nextState   = writeQ ? WRITE : RESP;
            end
            WRITE: begin
                mem_memWrite  = 1'b1;
                mem_writeData = alignStore;
                nextState     = RESP;
            end
            ERR: begin
                nextState = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                nextState  = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addrQ   <= '0;
            wdataQ  <= '0;
            oldQ    <= '0;
            rdataQ  <= '0;
            funct3Q <= '0;
            writeQ  <= 1'b0;
            errQ    <= 1'b0;
        end else if (accept) begin
            addrQ   <= req_addr;
            wdataQ  <= req_wdata;
            funct3Q <= req_funct3;
            writeQ  <= req_write;
            errQ    <= reqBad;
            rdataQ  <= '0;
        end else if (state == READ) begin
            if (writeQ) begin
                oldQ <= mem_readData;
            end else begin
                rdataQ <= alignLoad;
            end
        end
    end

    assign resp_rdata  = rdataQ;
    assign resp_error  = (state == RESP) && errQ;
    assign mem_address = {3'b000, addrQ[XLEN-1:3]};

endmodule
